pump_sequencer: RTL and testbench
=================================

PUMP_SEQUENCER -- requirements
Module: pump_sequencer

Interface
REQ-001 Parameter LOW_LVL, default 1, level at or below which pumping SHALL stop (0..9).
REQ-002 Parameter HIGH_LVL, default 8, level at or above which auto mode SHALL start pumping (0..9, > LOW_LVL).
REQ-003 Parameter TIMEOUT_CYC, default 200, maximum RUN cycles without a level change before a stall fault.
REQ-004 Parameter COOLDOWN_CYC, default 16, minimum pump-off cycles after every RUN exit.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 sensor_in  input  9  thermometer-coded tank level from the float-switch sensor.
REQ-008 start_req  input  1  single-cycle manual pump request.
REQ-009 stop_req  input  1  single-cycle manual stop request.
REQ-010 auto_en  input  1  level-driven automatic start enable.
REQ-011 fault_clr  input  1  single-cycle fault acknowledge.
REQ-012 pump_on  output  1  pump drive, registered, high only in RUN.
REQ-013 level  output  4  debounced level, 0..9.
REQ-014 state_o  output  2  IDLE=0, RUN=1, COOLDOWN=2, FAULT=3.
REQ-015 fault_code  output  2  0 none, 1 invalid sensor code, 2 stall timeout.
REQ-016 pump_cycles  output  16  count of cycles with pump_on high, saturating at 16'hFFFF.

Function
REQ-017 Valid sensor code SHALL be 0s above 1s only (2^n-1, n=0..9); decoded value = n.
REQ-018 sensor_in SHALL be registered each cycle; level SHALL update only when the same valid code is present on two consecutive samples (latency 2 cycles from input change).
REQ-019 Invalid code on two consecutive samples SHALL force FAULT with fault_code=1 from any state except FAULT; level SHALL hold its last value.
REQ-020 IDLE->RUN when (start_req or (auto_en and level>=HIGH_LVL)) and level>LOW_LVL and not stop_req; pump_on high on the cycle after the transition edge.
REQ-021 start_req with level<=LOW_LVL SHALL be ignored (stay IDLE).
REQ-022 RUN->COOLDOWN on stop_req or level<=LOW_LVL.
REQ-023 Stall counter SHALL clear on RUN entry and on every level change, increment each RUN cycle otherwise; reaching TIMEOUT_CYC SHALL force FAULT, fault_code=2.
REQ-024 Priority in RUN: invalid-code fault > stall fault > stop/low-level exit.
REQ-025 COOLDOWN SHALL last exactly COOLDOWN_CYC cycles then go to IDLE; start_req, stop_req and auto starts ignored during COOLDOWN.
REQ-026 FAULT: pump_on low; fault_clr SHALL move to COOLDOWN and clear fault_code; other requests ignored.
REQ-027 fault_clr in non-FAULT states SHALL have no effect.
REQ-028 pump_cycles SHALL increment each cycle pump_on=1, saturate, never clear except by reset.

Reset
REQ-029 rst SHALL immediately force state IDLE, pump_on=0, level=0, fault_code=0, pump_cycles=0, all counters and sensor registers 0, including mid-RUN and mid-COOLDOWN.
REQ-030 First valid level SHALL appear 2 cycles after rst deassertion given stable sensor_in.

Verification
REQ-031 sensor_in=9'h1FF, auto_en=1 after reset -> level=9 after 2 cycles, RUN next cycle, pump_on=1.
REQ-032 RUN, sensor_in stepped down to 9'h001 -> level=1, COOLDOWN next cycle, pump_on=0, IDLE after 16 cycles.
REQ-033 RUN with sensor_in held 9'h0FF for 200 cycles -> FAULT, fault_code=2; fault_clr -> COOLDOWN, fault_code=0.
REQ-034 sensor_in=9'h105 for 2 cycles in IDLE -> FAULT, fault_code=1, level unchanged.
REQ-035 start_req and stop_req same cycle in IDLE, level=5 -> stays IDLE; start_req alone -> RUN.
REQ-036 rst pulse mid-RUN with pump_cycles=37 -> pump_on=0, pump_cycles=0, IDLE immediately.

Source files
------------

// File: rtl/pump_sequencer.sv
// pump_sequencer: level-driven pump controller with sensor debounce, stall timeout and cooldown.
// Revision 1.0 - initial release.
`default_nettype none

module pump_sequencer #(
  parameter int LOW_LVL      = 1,
  parameter int HIGH_LVL     = 8,
  parameter int TIMEOUT_CYC  = 200,
  parameter int COOLDOWN_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  sensor_in,
  input  logic        start_req,
  input  logic        stop_req,
  input  logic        auto_en,
  input  logic        fault_clr,
  output logic        pump_on,
  output logic [3:0]  level,
  output logic [1:0]  state_o,
  output logic [1:0]  fault_code,
  output logic [15:0] pump_cycles
);

  localparam int TW = (TIMEOUT_CYC  > 1) ? $clog2(TIMEOUT_CYC)  : 1;
  localparam int CW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

  localparam logic [3:0]    c_low_lvl    = 4'(LOW_LVL);
  localparam logic [3:0]    c_high_lvl   = 4'(HIGH_LVL);
  localparam logic [TW-1:0] c_stall_last = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] c_cool_last  = CW'(COOLDOWN_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_COOLDOWN = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  state_t        r_state, w_state_d;
  logic [8:0]    r_samp;
  logic [3:0]    r_level;
  logic [1:0]    r_fault, w_fault_d;
  logic [TW-1:0] r_stall, w_stall_d;
  logic [CW-1:0] r_cool, w_cool_d;
  logic          r_pump;
  logic [15:0]   r_pcyc;

  logic          w_samp_ok, w_lvl_chg, w_bad;
  logic [3:0]    w_new_lvl;

  // A legal code is a run of ones from bit 0 upward, so adding one clears every set bit.
  function automatic logic is_therm(input logic [8:0] c);
    logic [9:0] p;
    p = {1'b0, c} + 10'd1;
    return (({1'b0, c} & p) == 10'd0);
  endfunction

  function automatic logic [3:0] therm_dec(input logic [8:0] c);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 9; i++) n = n + {3'b000, c[i]};
    return n;
  endfunction

  // Debounce compares the live input against the previous sample.
  assign w_new_lvl = therm_dec(sensor_in);
  assign w_samp_ok = is_therm(sensor_in) && (sensor_in == r_samp);
  assign w_lvl_chg = w_samp_ok && (w_new_lvl != r_level);
  assign w_bad     = !is_therm(sensor_in) && !is_therm(r_samp);

  always_comb begin
    w_state_d = r_state;
    w_fault_d = r_fault;
    w_stall_d = r_stall;
    w_cool_d  = r_cool;
    case (r_state)
      S_IDLE: begin
        if (w_bad) begin
          w_state_d = S_FAULT;
          w_fault_d = 2'd1;
        end else if ((start_req || (auto_en && r_level >= c_high_lvl)) &&
                     (r_level > c_low_lvl) && !stop_req) begin
          w_state_d = S_RUN;
          w_stall_d = '0;
        end
      end
      S_RUN: begin
        if (w_bad) begin
          w_state_d = S_FAULT;
          w_fault_d = 2'd1;
        end else if (!w_lvl_chg && r_stall == c_stall_last) begin
          w_state_d = S_FAULT;
          w_fault_d = 2'd2;
        end else begin
          w_stall_d = w_lvl_chg ? '0 : r_stall + TW'(1);
          if (stop_req || r_level <= c_low_lvl) begin
            w_state_d = S_COOLDOWN;
            w_cool_d  = '0;
          end
        end
      end
      S_COOLDOWN: begin
        if (w_bad) begin
          w_state_d = S_FAULT;
          w_fault_d = 2'd1;
        end else if (r_cool == c_cool_last) begin
          w_state_d = S_IDLE;
        end else begin
          w_cool_d = r_cool + CW'(1);
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          w_state_d = S_COOLDOWN;
          w_fault_d = 2'd0;
          w_cool_d  = '0;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_samp  <= '0;
      r_level <= '0;
      r_fault <= '0;
      r_stall <= '0;
      r_cool  <= '0;
      r_pump  <= 1'b0;
      r_pcyc  <= '0;
    end else begin
      r_state <= w_state_d;
      r_samp  <= sensor_in;
      if (w_samp_ok) r_level <= w_new_lvl;
      r_fault <= w_fault_d;
      r_stall <= w_stall_d;
      r_cool  <= w_cool_d;
      r_pump  <= (w_state_d == S_RUN);
      if (r_pump && r_pcyc != 16'hFFFF) r_pcyc <= r_pcyc + 16'd1;
    end
  end

  assign pump_on     = r_pump;
  assign level       = r_level;
  assign state_o     = r_state;
  assign fault_code  = r_fault;
  assign pump_cycles = r_pcyc;

endmodule

`default_nettype wire

// File: tb/tb_pump_sequencer.sv
// tb_pump_sequencer: directed self-checking bench for pump_sequencer.
// Revision 1.0 - initial release.
`default_nettype none

module tb_pump_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  sensor_in;
  logic        start_req, stop_req, auto_en, fault_clr;
  logic        pump_on;
  logic [3:0]  level;
  logic [1:0]  state_o, fault_code;
  logic [15:0] pump_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, COOL = 2'd2, FLT = 2'd3;

  pump_sequencer #(
    .LOW_LVL(1), .HIGH_LVL(8), .TIMEOUT_CYC(200), .COOLDOWN_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .sensor_in(sensor_in),
    .start_req(start_req), .stop_req(stop_req), .auto_en(auto_en),
    .fault_clr(fault_clr), .pump_on(pump_on), .level(level),
    .state_o(state_o), .fault_code(fault_code), .pump_cycles(pump_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; sensor_in = 9'h1FF; auto_en = 1'b1;
    start_req = 1'b0; stop_req = 1'b0; fault_clr = 1'b0;
    tick(2);
    chk("rst_state", state_o, IDLE);
    chk("rst_pump", pump_on, 0);
    chk("rst_level", level, 0);
    chk("rst_fault", fault_code, 0);
    chk("rst_pcyc", pump_cycles, 0);
    rst = 1'b0;

    // Full tank with auto enabled: level after two edges, RUN on the third.
    tick(1);
    chk("lvl_lat1", level, 0);
    tick(1);
    chk("lvl_9", level, 9);
    chk("idle_pre_run", state_o, IDLE);
    tick(1);
    chk("auto_run", state_o, RUN);
    chk("auto_pump", pump_on, 1);
    chk("pcyc_0", pump_cycles, 0);
    tick(1);
    chk("pcyc_1", pump_cycles, 1);

    // Drain to low level: COOLDOWN, then IDLE after 16 cycles.
    sensor_in = 9'h001;
    tick(2);
    chk("lvl_1", level, 1);
    chk("still_run", state_o, RUN);
    tick(1);
    chk("low_cool", state_o, COOL);
    chk("low_pump_off", pump_on, 0);
    chk("pcyc_4", pump_cycles, 4);
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
    chk("cool_ign_start", state_o, COOL);
    tick(14);
    chk("cool_15", state_o, COOL);
    tick(1);
    chk("cool_done", state_o, IDLE);

    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_idle_noop", state_o, IDLE);

    // Stall: level held at 8 for TIMEOUT_CYC run cycles.
    sensor_in = 9'h0FF;
    tick(2);
    chk("lvl_8", level, 8);
    tick(1);
    chk("stall_run", state_o, RUN);
    auto_en = 1'b0;
    tick(199);
    chk("stall_199", state_o, RUN);
    tick(1);
    chk("stall_fault", state_o, FLT);
    chk("stall_code", fault_code, 2);
    chk("stall_pump", pump_on, 0);
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
    chk("fault_ign_start", state_o, FLT);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_cool", state_o, COOL);
    chk("clr_code", fault_code, 0);
    tick(16);
    chk("clr_idle", state_o, IDLE);

    // Simultaneous start/stop at level 5 is rejected; start alone runs.
    sensor_in = 9'h01F;
    tick(2);
    chk("lvl_5", level, 5);
    start_req = 1'b1; stop_req = 1'b1;
    tick(1);
    stop_req = 1'b0;
    chk("start_stop_idle", state_o, IDLE);
    tick(1);
    start_req = 1'b0;
    chk("start_run", state_o, RUN);
    stop_req = 1'b1;
    tick(1);
    stop_req = 1'b0;
    chk("stop_cool", state_o, COOL);
    chk("pcyc_205", pump_cycles, 205);
    tick(16);
    chk("stop_idle", state_o, IDLE);

    // Invalid code twice in IDLE.
    sensor_in = 9'h105;
    tick(1);
    chk("bad_once", state_o, IDLE);
    tick(1);
    chk("bad_fault", state_o, FLT);
    chk("bad_code", fault_code, 1);
    chk("bad_lvl_hold", level, 5);
    sensor_in = 9'h01F;
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("bad_clr", state_o, COOL);
    tick(16);
    chk("bad_idle", state_o, IDLE);

    // Reset mid-run once pump_cycles reaches 37.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("rst2_lvl", level, 5);
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
    chk("rst2_run", state_o, RUN);
    tick(37);
    chk("pcyc_37", pump_cycles, 37);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", state_o, IDLE);
    chk("arst_pump", pump_on, 0);
    chk("arst_pcyc", pump_cycles, 0);
    chk("arst_level", level, 0);
    tick(1);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
